// File: rtl/hdd_spi_pkg.sv
// Shared opcodes, FSM state type and decode helper for the Gayle IDE SPI sequencer.
// Optional feature macro used by the design: HDD_SPI_IRQ_EN.
package hdd_spi_pkg;

   localparam logic [7:0] OP_TFR_WR = 8'b1000_0000;
   localparam logic [7:0] OP_TFR_RD = 8'b0000_0000;
   localparam logic [7:0] OP_STAT   = 8'hF0;
   localparam logic [7:0] OP_BLK_RD = 8'hA0;
   localparam logic [7:0] OP_BLK_WR = 8'hB0;
   localparam logic [7:0] TX_BAD    = 8'hFF;

   // Clocks from a register-select / FIFO-advance change until hdd_data_in is trusted.
   localparam logic [1:0] RD_LAT = 2'd2;

   typedef enum logic [2:0] {
      IDLE, CMD, TW_DAT, ST_DAT, RD_HI, RD_LO, WR_HI, WR_LO
   } state_e;

   // Task-file opcodes carry the register number in bits [2:0].
   function automatic logic tfr_match(input logic [7:0] b, input logic [7:0] op);
      return b[7:3] == op[7:3];
   endfunction

endpackage

// File: rtl/hdd_spi_edge.sv
// Edge detectors: frame-select falling edge and, with HDD_SPI_IRQ_EN, rising edge of either Gayle request.
module hdd_spi_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic spi_cs_n,
`ifdef HDD_SPI_IRQ_EN
   input  logic hdd_cmd_req,
   input  logic hdd_dat_req,
   output logic req_rise,
`endif
   output logic cs_fall
);

   logic cs_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cs_q <= 1'b1;
      else          cs_q <= spi_cs_n;
   end

   assign cs_fall = cs_q & ~spi_cs_n;

`ifdef HDD_SPI_IRQ_EN
   logic [1:0] req_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) req_q <= 2'b00;
      else          req_q <= {hdd_dat_req, hdd_cmd_req};
   end

   assign req_rise = |({hdd_dat_req, hdd_cmd_req} & ~req_q);
`endif

endmodule

// File: rtl/hdd_spi_ctrl.sv
// Byte-stream sequencer from the SPI slave to the Gayle hdd_* bus (task file, status, sector FIFO).
// Define HDD_SPI_IRQ_EN to add the host_irq output.
module hdd_spi_ctrl
   import hdd_spi_pkg::*;
#(
   parameter int BLK_WORDS   = 256,
   parameter bit ABORT_FLUSH = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        spi_cs_n,
   input  logic [7:0]  rx_byte,
   input  logic        rx_stb,
   output logic [7:0]  tx_byte,
   input  logic        hdd_cmd_req,
   input  logic        hdd_dat_req,
   input  logic [15:0] hdd_data_in,
   output logic [2:0]  hdd_addr,
   output logic [15:0] hdd_data_out,
   output logic        hdd_wr,
   output logic        hdd_status_wr,
   output logic        hdd_data_wr,
   output logic        hdd_data_rd
`ifdef HDD_SPI_IRQ_EN
   ,
   output logic        host_irq
`endif
);

   localparam int CNT_W = $clog2(BLK_WORDS);

   state_e            state_q, state_d;
   logic [7:0]        tx_q, tx_d;
   logic [2:0]        addr_q, addr_d;
   logic [15:0]       dout_q, dout_d;
   logic              wr_q, wr_d, stwr_q, stwr_d, dwr_q, dwr_d, drd_q, drd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        hi_q, hi_d, lo_q, lo_d;
   logic              pend_q, pend_d;
   logic [1:0]        wait_q, wait_d;
   logic              last;
   logic              cs_fall;

`ifdef HDD_SPI_IRQ_EN
   logic req_rise;
   logic irq_q;
`endif

   hdd_spi_edge u_edge (
      .clk         (clk),
      .reset_n     (reset_n),
      .spi_cs_n    (spi_cs_n),
`ifdef HDD_SPI_IRQ_EN
      .hdd_cmd_req (hdd_cmd_req),
      .hdd_dat_req (hdd_dat_req),
      .req_rise    (req_rise),
`endif
      .cs_fall     (cs_fall)
   );

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      wr_d    = 1'b0;
      stwr_d  = 1'b0;
      dwr_d   = 1'b0;
      drd_d   = 1'b0;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      pend_d  = pend_q;
      wait_d  = wait_q;
      last    = (cnt_q == CNT_W'(BLK_WORDS - 1));

      // Deferred sample of hdd_data_in once the new address / FIFO word has settled.
      if (pend_q) begin
         if (wait_q != 2'd0) begin
            wait_d = wait_q - 2'd1;
         end else begin
            pend_d = 1'b0;
            if (state_q == RD_HI) begin
               tx_d = hdd_data_in[15:8];
               lo_d = hdd_data_in[7:0];
            end else begin
               tx_d = hdd_data_in[7:0];
            end
         end
      end

      if (spi_cs_n) begin
         state_d = IDLE;
         cnt_d   = '0;
         pend_d  = 1'b0;
         if (!ABORT_FLUSH && state_q == WR_LO) begin
            dout_d = {hi_q, 8'h00};
            dwr_d  = 1'b1;
         end
      end else if (cs_fall) begin
         state_d = CMD;
         tx_d    = {6'b0, hdd_dat_req, hdd_cmd_req};
         pend_d  = 1'b0;
      end else if (rx_stb) begin
         unique case (state_q)
            CMD: begin
               if (tfr_match(rx_byte, OP_TFR_WR)) begin
                  addr_d  = rx_byte[2:0];
                  state_d = TW_DAT;
               end else if (tfr_match(rx_byte, OP_TFR_RD)) begin
                  addr_d = rx_byte[2:0];
                  pend_d = 1'b1;
                  wait_d = RD_LAT;
               end else if (rx_byte == OP_STAT) begin
                  state_d = ST_DAT;
               end else if (rx_byte == OP_BLK_RD) begin
                  addr_d  = 3'd0;
                  state_d = RD_HI;
                  pend_d  = 1'b1;
                  wait_d  = RD_LAT;
               end else if (rx_byte == OP_BLK_WR) begin
                  addr_d  = 3'd0;
                  state_d = WR_HI;
               end else begin
                  tx_d = TX_BAD;
               end
            end
            TW_DAT: begin
               dout_d  = {8'h00, rx_byte};
               wr_d    = 1'b1;
               state_d = CMD;
            end
            ST_DAT: begin
               dout_d[7:0] = rx_byte;
               stwr_d      = 1'b1;
               state_d     = CMD;
            end
            RD_HI: begin
               tx_d    = pend_q ? hdd_data_in[7:0] : lo_q;
               pend_d  = 1'b0;
               state_d = RD_LO;
            end
            RD_LO: begin
               drd_d   = 1'b1;
               cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
               state_d = last ? CMD : RD_HI;
               pend_d  = ~last;
               wait_d  = RD_LAT;
            end
            WR_HI: begin
               hi_d    = rx_byte;
               state_d = WR_LO;
            end
            WR_LO: begin
               dout_d  = {hi_q, rx_byte};
               dwr_d   = 1'b1;
               cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
               state_d = last ? CMD : WR_HI;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         tx_q    <= 8'h00;
         addr_q  <= 3'd0;
         dout_q  <= 16'h0000;
         wr_q    <= 1'b0;
         stwr_q  <= 1'b0;
         dwr_q   <= 1'b0;
         drd_q   <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= 8'h00;
         lo_q    <= 8'h00;
         pend_q  <= 1'b0;
         wait_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         wr_q    <= wr_d;
         stwr_q  <= stwr_d;
         dwr_q   <= dwr_d;
         drd_q   <= drd_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         pend_q  <= pend_d;
         wait_q  <= wait_d;
      end
   end

`ifdef HDD_SPI_IRQ_EN
   // A request edge in the same clock as frame start must not be lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      irq_q <= 1'b0;
      else if (req_rise) irq_q <= 1'b1;
      else if (cs_fall)  irq_q <= 1'b0;
   end

   assign host_irq = irq_q;
`endif

   assign tx_byte       = tx_q;
   assign hdd_addr      = addr_q;
   assign hdd_data_out  = dout_q;
   assign hdd_wr        = wr_q;
   assign hdd_status_wr = stwr_q;
   assign hdd_data_wr   = dwr_q;
   assign hdd_data_rd   = drd_q;

endmodule

// File: tb/tb_hdd_spi_ctrl.sv
// Self-checking bench for hdd_spi_ctrl: vector table, randomized register traffic, block and abort sequences.
module tb_hdd_spi_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        spi_cs_n;
   logic [7:0]  rx_byte;
   logic        rx_stb;
   logic [7:0]  tx_byte;
   logic        hdd_cmd_req;
   logic        hdd_dat_req;
   logic [15:0] hdd_data_in;
   logic [2:0]  hdd_addr;
   logic [15:0] hdd_data_out;
   logic        hdd_wr;
   logic        hdd_status_wr;
   logic        hdd_data_wr;
   logic        hdd_data_rd;
`ifdef HDD_SPI_IRQ_EN
   logic        host_irq;
`endif

   always #5 clk = ~clk;

   hdd_spi_ctrl dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .spi_cs_n      (spi_cs_n),
      .rx_byte       (rx_byte),
      .rx_stb        (rx_stb),
      .tx_byte       (tx_byte),
      .hdd_cmd_req   (hdd_cmd_req),
      .hdd_dat_req   (hdd_dat_req),
      .hdd_data_in   (hdd_data_in),
      .hdd_addr      (hdd_addr),
      .hdd_data_out  (hdd_data_out),
      .hdd_wr        (hdd_wr),
      .hdd_status_wr (hdd_status_wr),
      .hdd_data_wr   (hdd_data_wr),
      .hdd_data_rd   (hdd_data_rd)
`ifdef HDD_SPI_IRQ_EN
      ,
      .host_irq      (host_irq)
`endif
   );

   // Gayle side: task-file bytes and a sector FIFO that advances on hdd_data_rd.
   logic [7:0]  tfr [8];
   logic [15:0] rd_mem [512];
   int          rd_ptr = 0;

   assign hdd_data_in = (hdd_addr == 3'd0) ? rd_mem[rd_ptr[8:0]] : {8'h00, tfr[hdd_addr]};

   always @(posedge clk) if (hdd_data_rd) rd_ptr <= rd_ptr + 1;

   int          wr_cnt = 0, st_cnt = 0, dwr_cnt = 0, drd_cnt = 0, addr_bad = 0;
   logic [15:0] wr_log [$];

   always @(negedge clk) begin
      if (hdd_wr) wr_cnt++;
      if (hdd_status_wr) st_cnt++;
      if (hdd_data_wr) begin
         dwr_cnt++;
         wr_log.push_back(hdd_data_out);
      end
      if (hdd_data_rd) drd_cnt++;
      if ((hdd_data_wr || hdd_data_rd) && hdd_addr != 3'd0) addr_bad++;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame_start(input logic creq, input logic dreq);
      hdd_cmd_req = creq;
      hdd_dat_req = dreq;
      tick(2);
      spi_cs_n = 1'b0;
      tick(3);
   endtask

   task automatic frame_end();
      spi_cs_n = 1'b1;
      tick(4);
   endtask

   // seen = byte the controller shifts out during this slot
   task automatic send(input logic [7:0] b, output logic [7:0] seen);
      seen    = tx_byte;
      rx_byte = b;
      rx_stb  = 1'b1;
      tick(1);
      rx_stb  = 1'b0;
      tick(7);
   endtask

   function automatic logic is_valid_op(input logic [7:0] x);
      return (x[7:3] == 5'b10000) || (x[7:3] == 5'b00000) ||
             (x == 8'hF0) || (x == 8'hA0) || (x == 8'hB0);
   endfunction

   typedef struct {
      logic [7:0]  cmd;
      logic [7:0]  dat;
      logic        creq;
      logic        dreq;
      logic [7:0]  exp_stat;
      logic        chk_tx;
      logic [7:0]  exp_tx;
      logic [2:0]  exp_addr;
      logic [15:0] dmask;
      logic [15:0] exp_dout;
      int          exp_wr;
      int          exp_st;
   } vec_t;

   vec_t tbl [7];

   initial begin
      logic [7:0]  s0, s1, cmd, dat, etx, b;
      logic [2:0]  a, m_addr;
      logic [15:0] m_dout, w;
      logic        creq, dreq, chk;
      int          w0, st0, d0, r0, base, op, ewr, est;

      tbl[0] = '{8'h82, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 3'd2, 16'hFFFF, 16'h005A, 1, 0};
      tbl[1] = '{8'h85, 8'h3C, 1'b1, 1'b0, 8'h01, 1'b0, 8'h00, 3'd5, 16'hFFFF, 16'h003C, 1, 0};
      tbl[2] = '{8'hF0, 8'h88, 1'b1, 1'b1, 8'h03, 1'b0, 8'h00, 3'd5, 16'h00FF, 16'h0088, 0, 1};
      tbl[3] = '{8'h07, 8'hFF, 1'b0, 1'b1, 8'h02, 1'b1, 8'hC7, 3'd7, 16'h00FF, 16'h0088, 0, 0};
      tbl[4] = '{8'h13, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 3'd7, 16'h00FF, 16'h0088, 0, 0};
      tbl[5] = '{8'h80, 8'hFF, 1'b1, 1'b0, 8'h01, 1'b0, 8'h00, 3'd0, 16'hFFFF, 16'h00FF, 1, 0};
      tbl[6] = '{8'h02, 8'hFF, 1'b0, 1'b1, 8'h02, 1'b1, 8'hC2, 3'd2, 16'hFFFF, 16'h00FF, 0, 0};

      for (int i = 0; i < 8; i++) tfr[i] = 8'hC0 + 8'(i);
      rd_mem[0] = 16'h1234;
      rd_mem[1] = 16'h5678;
      for (int i = 2; i < 512; i++) rd_mem[i] = 16'($urandom);

      reset_n = 1'b0; spi_cs_n = 1'b1; rx_byte = 8'h00; rx_stb = 1'b0;
      hdd_cmd_req = 1'b0; hdd_dat_req = 1'b0;
      tick(3);
      check("reset tx_byte", tx_byte, 8'h00);
      check("reset hdd_addr", hdd_addr, 3'd0);
      reset_n = 1'b1;
      tick(3);
      check("post-reset tx_byte", tx_byte, 8'h00);
      check("post-reset hdd_data_out", hdd_data_out, 16'h0000);
      check("post-reset strobes", {hdd_wr, hdd_status_wr, hdd_data_wr, hdd_data_rd}, 4'b0000);
      $display("reset: tx %h addr %0d dout %h", tx_byte, hdd_addr, hdd_data_out);

`ifdef HDD_SPI_IRQ_EN
      check("irq after reset", host_irq, 1'b0);
      hdd_cmd_req = 1'b1;
      tick(3);
      check("irq on cmd_req rise", host_irq, 1'b1);
      spi_cs_n = 1'b0;
      tick(3);
      check("irq cleared at frame start", host_irq, 1'b0);
      frame_end();
      hdd_cmd_req = 1'b0;
      $display("irq: set on request edge, cleared at frame start");
`endif

      // Two-byte register transactions from the table
      for (int i = 0; i < 7; i++) begin
         w0 = wr_cnt; st0 = st_cnt;
         frame_start(tbl[i].creq, tbl[i].dreq);
         send(tbl[i].cmd, s0);
         send(tbl[i].dat, s1);
         frame_end();
         check($sformatf("row%0d status byte", i), s0, tbl[i].exp_stat);
         if (tbl[i].chk_tx) check($sformatf("row%0d tx slot2", i), s1, tbl[i].exp_tx);
         check($sformatf("row%0d hdd_addr", i), hdd_addr, tbl[i].exp_addr);
         check($sformatf("row%0d hdd_data_out", i), hdd_data_out & tbl[i].dmask, tbl[i].exp_dout);
         check($sformatf("row%0d hdd_wr pulses", i), wr_cnt - w0, tbl[i].exp_wr);
         check($sformatf("row%0d status_wr pulses", i), st_cnt - st0, tbl[i].exp_st);
         $display("row %0d: cmd %h dat %h status %h tx2 %h addr %0d dout %h", i,
                  tbl[i].cmd, tbl[i].dat, s0, s1, hdd_addr, hdd_data_out);
      end

      // Randomized register traffic against a transaction-level model
      m_addr = 3'd2;
      m_dout = 16'h00FF;
      for (int t = 0; t < 40; t++) begin
         op = $urandom_range(0, 3);
         creq = 1'($urandom_range(0, 1));
         dreq = 1'($urandom_range(0, 1));
         a = 3'($urandom_range(1, 7));
         b = 8'($urandom);
         chk = 1'b0; etx = 8'h00; ewr = 0; est = 0;
         case (op)
            0: begin cmd = 8'h80 + 8'(a); dat = b; m_addr = a; m_dout = {8'h00, b}; ewr = 1; end
            1: begin cmd = 8'(a); dat = 8'hFF; m_addr = a; chk = 1'b1; etx = 8'hC0 + 8'(a); end
            2: begin cmd = 8'hF0; dat = b; m_dout[7:0] = b; est = 1; end
            default: begin
               do cmd = 8'($urandom); while (is_valid_op(cmd));
               do dat = 8'($urandom); while (is_valid_op(dat));
               chk = 1'b1; etx = 8'hFF;
            end
         endcase
         w0 = wr_cnt; st0 = st_cnt;
         frame_start(creq, dreq);
         send(cmd, s0);
         send(dat, s1);
         frame_end();
         check($sformatf("rnd%0d status byte", t), s0, {6'b0, dreq, creq});
         if (chk) check($sformatf("rnd%0d tx slot2", t), s1, etx);
         check($sformatf("rnd%0d hdd_addr", t), hdd_addr, m_addr);
         check($sformatf("rnd%0d hdd_data_out", t), hdd_data_out, m_dout);
         check($sformatf("rnd%0d hdd_wr pulses", t), wr_cnt - w0, ewr);
         check($sformatf("rnd%0d status_wr pulses", t), st_cnt - st0, est);
         $display("rnd %0d: cmd %h dat %h status %h tx2 %h addr %0d dout %h", t,
                  cmd, dat, s0, s1, hdd_addr, hdd_data_out);
      end

      // Abort while waiting for the task-file data byte
      w0 = wr_cnt;
      frame_start(1'b0, 1'b0);
      send(8'h82, s0);
      frame_end();
      check("abort TW_DAT no hdd_wr", wr_cnt - w0, 0);
      $display("abort TW_DAT: hdd_wr pulses %0d", wr_cnt - w0);

      // Byte strobe coincident with frame deselect is dropped
      w0 = wr_cnt;
      frame_start(1'b0, 1'b0);
      send(8'h85, s0);
      rx_byte = 8'h77; rx_stb = 1'b1; spi_cs_n = 1'b1;
      tick(1);
      rx_stb = 1'b0;
      tick(4);
      check("coincident abort no hdd_wr", wr_cnt - w0, 0);
      check("coincident abort hdd_addr", hdd_addr, 3'd5);
      $display("coincident abort: hdd_wr pulses %0d addr %0d", wr_cnt - w0, hdd_addr);

      // Abort mid-word in a block write: only the complete word is written
      d0 = dwr_cnt; base = wr_log.size();
      frame_start(1'b0, 1'b0);
      send(8'hB0, s0);
      send(8'h11, s0);
      send(8'h22, s0);
      send(8'h33, s0);
      frame_end();
      check("abort BLK_WR data_wr pulses", dwr_cnt - d0, 1);
      if (wr_log.size() > base) check("abort BLK_WR word", wr_log[base], 16'h1122);
      check("abort BLK_WR hdd_addr", hdd_addr, 3'd0);
      $display("abort BLK_WR: data_wr pulses %0d", dwr_cnt - d0);

      // Full block write in a fresh frame; counter must have restarted at 0
      d0 = dwr_cnt; base = wr_log.size(); w0 = wr_cnt;
      frame_start(1'b0, 1'b0);
      send(8'hB0, s0);
      for (int k = 0; k < 512; k++) send(8'(k), s1);
      send(8'h82, s0);
      send(8'h44, s0);
      frame_end();
      check("BLK_WR data_wr pulses", dwr_cnt - d0, 256);
      for (int n = 0; n < 256; n++)
         if (base + n < wr_log.size())
            check($sformatf("BLK_WR word%0d", n), wr_log[base + n], {8'(2 * n), 8'(2 * n + 1)});
      check("BLK_WR back in CMD hdd_wr", wr_cnt - w0, 1);
      check("BLK_WR back in CMD dout", hdd_data_out, 16'h0044);
      $display("BLK_WR: %0d words written, trailing TFR_WR pulses %0d", dwr_cnt - d0, wr_cnt - w0);

      // Full block read: FIFO words shifted out hi then lo
      r0 = drd_cnt; w0 = wr_cnt;
      frame_start(1'b0, 1'b1);
      send(8'hA0, s0);
      for (int j = 0; j < 512; j++) begin
         send(8'($urandom), s1);
         w = rd_mem[j / 2];
         check($sformatf("BLK_RD slot%0d", j), s1, (j % 2 == 0) ? w[15:8] : w[7:0]);
      end
      send(8'h82, s0);
      send(8'h55, s0);
      frame_end();
      check("BLK_RD data_rd pulses", drd_cnt - r0, 256);
      check("block hdd_addr zero at strobes", addr_bad, 0);
      check("BLK_RD back in CMD hdd_wr", wr_cnt - w0, 1);
      $display("BLK_RD: %0d data_rd pulses, first word %h", drd_cnt - r0, rd_mem[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
